conv3x3_stream: RTL and testbench

- Parametrised 3x3 convolution engine for streaming grayscale video. It generalises the fixed 12-bit, 640-wide, two-kernel filter.
- Adds generic pixel and line widths, runtime-programmable coefficients with frame-synchronous shadow commit, right-shift normalisation, selectable abs/offset output, and border detection/handling.
- Sits between the gray-conversion stage and the display/VGA writer.

---
 rtl/conv3x3_pkg.sv | 31 +++
 rtl/conv3x3_stream_line_buffer.sv | 42 ++++
 rtl/conv3x3_stream.sv | 217 +++++++++++++++++++++
 tb/tb_conv3x3_stream.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv3x3_pkg.sv
// Shared types, constants and helpers for the 3x3 streaming convolution engine.
package conv3x3_pkg;

  localparam int NUM_TAPS = 9;

  typedef enum logic [3:0] {
    K00 = 4'd0, K01 = 4'd1, K02 = 4'd2,
    K10 = 4'd3, K11 = 4'd4, K12 = 4'd5,
    K20 = 4'd6, K21 = 4'd7, K22 = 4'd8
  } coef_idx_e;

  localparam int SOBEL_X_DEFAULT [NUM_TAPS] = '{
    -32'sd1, 32'sd0, 32'sd1,
    -32'sd2, 32'sd0, 32'sd2,
    -32'sd1, 32'sd0, 32'sd1
  };

  // Saturate a signed value into the unsigned pixel range [0, 2^pix_w-1].
  function automatic logic [31:0] clamp_u(input logic signed [63:0] acc, input int unsigned pix_w);
    logic signed [63:0] max_v;
    max_v = (64'sd1 <<< pix_w) - 64'sd1;
    if (acc < 64'sd0) begin
      clamp_u = 32'd0;
    end else if (acc > max_v) begin
      clamp_u = max_v[31:0];
    end else begin
      clamp_u = acc[31:0];
    end
  endfunction

endpackage

// File: rtl/conv3x3_stream_line_buffer.sv
// Two cascaded line delays in a circular RAM; taps return the pixel one and
// two lines above the incoming one.
module line_buffer_2row #(
  parameter int PIX_W = 12,
  parameter int DEPTH = 640
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             iDVAL,
  input  logic [PIX_W-1:0] iPIX,
  output logic [PIX_W-1:0] oTAP1,
  output logic [PIX_W-1:0] oTAP2
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PIX_W-1:0] row1_mem [DEPTH];
  logic [PIX_W-1:0] row2_mem [DEPTH];
  logic [PTR_W-1:0] ptr_r;

  // Read-before-write: the slot still holds the value written DEPTH pixels ago.
  assign oTAP1 = row1_mem[ptr_r];
  assign oTAP2 = row2_mem[ptr_r];

  // Circular write pointer, advancing once per valid pixel.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      ptr_r <= {PTR_W{1'b0}};
    end else if (iDVAL) begin
      ptr_r <= (ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : ptr_r + PTR_W'(1);
    end
  end

  // RAM storage; the second line is fed from the first line's output.
  always_ff @(posedge iCLK) begin
    if (iDVAL) begin
      row1_mem[ptr_r] <= iPIX;
      row2_mem[ptr_r] <= row1_mem[ptr_r];
    end
  end

endmodule

// File: rtl/conv3x3_stream.sv
// 3x3 streaming convolution with programmable shadowed kernel, shift
// normalisation, abs/offset output and border flagging; 3-cycle latency.
module conv3x3_stream
  import conv3x3_pkg::*;
#(
  parameter int PIX_W  = 12,
  parameter int IMG_W  = 640,
  parameter int COEF_W = 8,
  parameter int ACC_W  = PIX_W + COEF_W + 5
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic [PIX_W-1:0]  iPIX,
  input  logic              iDVAL,
  input  logic              iSOF,
  input  logic              iCONV_EN,
  input  logic              iABS,
  input  logic              iBORDER_ZERO,
  input  logic [3:0]        iSHIFT,
  input  logic              iCOEF_WE,
  input  logic [3:0]        iCOEF_ADDR,
  input  logic [COEF_W-1:0] iCOEF_DATA,
  output logic [PIX_W-1:0]  oPIX,
  output logic              oDVAL,
  output logic              oEDGE
);

  localparam int PROD_W = PIX_W + COEF_W + 1;

  logic [15:0]              x_r, y_r, cur_x_s, cur_y_s;
  logic                     edge_s, commit_s, wr_ok_s;
  logic [PIX_W-1:0]         tap1_s, tap2_s;
  logic [PIX_W-1:0]         top_r [2];
  logic [PIX_W-1:0]         mid_r [2];
  logic [PIX_W-1:0]         bot_r [2];
  logic [PIX_W-1:0]         win_s [NUM_TAPS];
  logic signed [COEF_W-1:0] act_r [NUM_TAPS];
  logic signed [COEF_W-1:0] shd_r [NUM_TAPS];
  logic signed [COEF_W-1:0] shd_nxt_s [NUM_TAPS];
  logic signed [COEF_W-1:0] coef_s [NUM_TAPS];
  logic signed [PROD_W-1:0] prod_s [NUM_TAPS];
  logic signed [PROD_W-1:0] s1_prod_r [NUM_TAPS];
  logic [PIX_W-1:0]         s1_ctr_r, s2_ctr_r, res_s;
  logic                     s1_vld_r, s2_vld_r, s1_edge_r, s2_edge_r;
  logic signed [ACC_W-1:0]  sum_s, s2_acc_r;
  logic signed [63:0]       acc64_s, abs64_s, off64_s;

  line_buffer_2row #(.PIX_W(PIX_W), .DEPTH(IMG_W)) u_line_buffer (
    .iCLK  (iCLK),
    .iRST  (iRST),
    .iDVAL (iDVAL),
    .iPIX  (iPIX),
    .oTAP1 (tap1_s),
    .oTAP2 (tap2_s)
  );

  // Coordinates of the incoming pixel; SOF pins it to the frame origin.
  always_comb begin
    cur_x_s  = iSOF ? 16'd0 : x_r;
    cur_y_s  = iSOF ? 16'd0 : y_r;
    edge_s   = (cur_x_s < 16'd2) || (cur_y_s < 16'd2);
    commit_s = iSOF & iDVAL;
  end

  // Raster counters: x wraps at line end, y saturates.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      x_r <= 16'd0;
      y_r <= 16'd0;
    end else if (iDVAL) begin
      if (cur_x_s == 16'(IMG_W - 1)) begin
        x_r <= 16'd0;
        y_r <= (cur_y_s == 16'hFFFF) ? cur_y_s : cur_y_s + 16'd1;
      end else begin
        x_r <= cur_x_s + 16'd1;
        y_r <= cur_y_s;
      end
    end
  end

  // Window registers: two horizontal delays per row.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < 2; i++) begin
        top_r[i] <= {PIX_W{1'b0}};
        mid_r[i] <= {PIX_W{1'b0}};
        bot_r[i] <= {PIX_W{1'b0}};
      end
    end else if (iDVAL) begin
      top_r[1] <= top_r[0];
      top_r[0] <= tap2_s;
      mid_r[1] <= mid_r[0];
      mid_r[0] <= tap1_s;
      bot_r[1] <= bot_r[0];
      bot_r[0] <= iPIX;
    end
  end

  // Row-major window (k00 = oldest line, oldest column) and the kernel it meets;
  // on the commit cycle the merged shadow is used so this pixel sees the new kernel.
  always_comb begin
    win_s[0] = top_r[1];
    win_s[1] = top_r[0];
    win_s[2] = tap2_s;
    win_s[3] = mid_r[1];
    win_s[4] = mid_r[0];
    win_s[5] = tap1_s;
    win_s[6] = bot_r[1];
    win_s[7] = bot_r[0];
    win_s[8] = iPIX;
    wr_ok_s  = iCOEF_WE && (iCOEF_ADDR <= 4'(K22));
    for (int i = 0; i < NUM_TAPS; i++) begin
      shd_nxt_s[i] = shd_r[i];
      if (wr_ok_s && (iCOEF_ADDR == 4'(i))) begin
        shd_nxt_s[i] = iCOEF_DATA;
      end else begin
        shd_nxt_s[i] = shd_r[i];
      end
      coef_s[i] = commit_s ? shd_nxt_s[i] : act_r[i];
      prod_s[i] = PROD_W'($signed({1'b0, win_s[i]})) * PROD_W'(coef_s[i]);
    end
  end

  // Shadow kernel takes writes; active kernel loads only at frame start.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        shd_r[i] <= COEF_W'(SOBEL_X_DEFAULT[i]);
        act_r[i] <= COEF_W'(SOBEL_X_DEFAULT[i]);
      end
    end else begin
      for (int i = 0; i < NUM_TAPS; i++) begin
        shd_r[i] <= shd_nxt_s[i];
        if (commit_s) begin
          act_r[i] <= shd_nxt_s[i];
        end
      end
    end
  end

  // S1: products, centre pixel and border flag.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      s1_vld_r  <= 1'b0;
      s1_ctr_r  <= {PIX_W{1'b0}};
      s1_edge_r <= 1'b0;
      for (int i = 0; i < NUM_TAPS; i++) begin
        s1_prod_r[i] <= {PROD_W{1'b0}};
      end
    end else begin
      s1_vld_r  <= iDVAL;
      s1_ctr_r  <= win_s[4];
      s1_edge_r <= edge_s;
      for (int i = 0; i < NUM_TAPS; i++) begin
        s1_prod_r[i] <= prod_s[i];
      end
    end
  end

  // Adder tree over the registered products.
  always_comb begin
    sum_s = {ACC_W{1'b0}};
    for (int i = 0; i < NUM_TAPS; i++) begin
      sum_s = sum_s + ACC_W'(s1_prod_r[i]);
    end
  end

  // S2: normalised accumulator.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      s2_vld_r  <= 1'b0;
      s2_acc_r  <= {ACC_W{1'b0}};
      s2_ctr_r  <= {PIX_W{1'b0}};
      s2_edge_r <= 1'b0;
    end else begin
      s2_vld_r  <= s1_vld_r;
      s2_acc_r  <= sum_s >>> iSHIFT;
      s2_ctr_r  <= s1_ctr_r;
      s2_edge_r <= s1_edge_r;
    end
  end

  // Output mapping: bypass, magnitude or mid-scale offset, then border forcing.
  always_comb begin
    acc64_s = 64'(s2_acc_r);
    abs64_s = (acc64_s < 64'sd0) ? -acc64_s : acc64_s;
    off64_s = acc64_s + (64'sd1 <<< (PIX_W - 1));
    if (!iCONV_EN) begin
      res_s = s2_ctr_r;
    end else if (iABS) begin
      res_s = PIX_W'(clamp_u(abs64_s, 32'(PIX_W)));
    end else begin
      res_s = PIX_W'(clamp_u(off64_s, 32'(PIX_W)));
    end
    if (iBORDER_ZERO && s2_edge_r) begin
      res_s = {PIX_W{1'b0}};
    end else begin
      res_s = res_s;
    end
  end

  // S3: output register, holding between valid pixels.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      oDVAL <= 1'b0;
      oPIX  <= {PIX_W{1'b0}};
      oEDGE <= 1'b0;
    end else begin
      oDVAL <= s2_vld_r;
      if (s2_vld_r) begin
        oPIX  <= res_s;
        oEDGE <= s2_edge_r;
      end
    end
  end

endmodule

// File: tb/tb_conv3x3_stream.sv
// Self-checking bench: pixel-history reference model plus hand-computed spot values.
module tb_conv3x3_stream;

  localparam int PIX_W  = 12;
  localparam int IMG_W  = 8;
  localparam int COEF_W = 8;
  localparam int ACC_W  = PIX_W + COEF_W + 5;
  localparam int PMAX   = (1 << PIX_W) - 1;
  localparam int PMID   = 1 << (PIX_W - 1);

  logic              iCLK = 1'b0;
  logic              iRST = 1'b0;
  logic [PIX_W-1:0]  iPIX = '0;
  logic              iDVAL = 1'b0, iSOF = 1'b0;
  logic              iCONV_EN = 1'b1, iABS = 1'b1, iBORDER_ZERO = 1'b0;
  logic [3:0]        iSHIFT = 4'd0;
  logic              iCOEF_WE = 1'b0;
  logic [3:0]        iCOEF_ADDR = 4'd0;
  logic [COEF_W-1:0] iCOEF_DATA = '0;
  logic [PIX_W-1:0]  oPIX;
  logic              oDVAL, oEDGE;

  conv3x3_stream #(.PIX_W(PIX_W), .IMG_W(IMG_W), .COEF_W(COEF_W), .ACC_W(ACC_W)) dut (
    .iCLK(iCLK), .iRST(iRST), .iPIX(iPIX), .iDVAL(iDVAL), .iSOF(iSOF),
    .iCONV_EN(iCONV_EN), .iABS(iABS), .iBORDER_ZERO(iBORDER_ZERO), .iSHIFT(iSHIFT),
    .iCOEF_WE(iCOEF_WE), .iCOEF_ADDR(iCOEF_ADDR), .iCOEF_DATA(iCOEF_DATA),
    .oPIX(oPIX), .oDVAL(oDVAL), .oEDGE(oEDGE)
  );

  always #5 iCLK = ~iCLK;

  typedef struct { int pix; bit edg; bit chk; } exp_t;

  exp_t     exp_q [$];
  int       hist [$];
  int       out_pix [$];
  bit       out_edg [$];
  int       checks = 0;
  int       errors = 0;
  int       m_x, m_y;
  int       sh_k [9];
  int       act_k [9];
  logic [2:0] dv_sh = 3'b000;
  const int sobel [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic lit(input string name, input int idx, input int pix, input int edg);
    checks++;
    if (idx >= out_pix.size()) begin
      errors++;
      $display("FAIL %s: output %0d never produced", name, idx);
    end else if (out_pix[idx] != pix || int'(out_edg[idx]) != edg) begin
      errors++;
      $display("FAIL %s: got pix %0d edge %0d expected pix %0d edge %0d",
               name, out_pix[idx], out_edg[idx], pix, edg);
    end
  endtask

  function automatic int clampi(input int v);
    return (v < 0) ? 0 : ((v > PMAX) ? PMAX : v);
  endfunction

  task automatic model_reset();
    hist.delete();
    exp_q.delete();
    m_x = 0;
    m_y = 0;
    for (int i = 0; i < 9; i++) begin
      sh_k[i]  = sobel[i];
      act_k[i] = sobel[i];
    end
  endtask

  // Apply one cycle of inputs, update the reference model, advance one clock.
  task automatic step(input int pix, input bit dval, input bit sof,
                      input bit we = 1'b0, input int addr = 0, input int data = 0);
    exp_t e;
    int   n, acc, acc_sh;
    iPIX = pix[PIX_W-1:0];
    iDVAL = dval;
    iSOF = sof;
    iCOEF_WE = we;
    iCOEF_ADDR = addr[3:0];
    iCOEF_DATA = data[COEF_W-1:0];
    if (we && addr < 9) sh_k[addr] = data;
    if (dval) begin
      if (sof) begin
        m_x = 0;
        m_y = 0;
        act_k = sh_k;
      end
      hist.push_back(pix);
      n = hist.size() - 1;
      e.edg = (m_x < 2) || (m_y < 2);
      e.chk = (n >= 2 * IMG_W + 2);
      e.pix = 0;
      if (e.chk) begin
        acc = 0;
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            acc += act_k[r*3+c] * hist[n - (2-r)*IMG_W - (2-c)];
        acc_sh = acc >>> iSHIFT;
        if (!iCONV_EN) e.pix = hist[n - IMG_W - 1];
        else if (iABS) e.pix = clampi((acc_sh < 0) ? -acc_sh : acc_sh);
        else e.pix = clampi(acc_sh + PMID);
      end
      if (iBORDER_ZERO && e.edg) begin
        e.pix = 0;
        e.chk = 1'b1;
      end
      exp_q.push_back(e);
      if (m_x == IMG_W - 1) begin
        m_x = 0;
        if (m_y < 65535) m_y++;
      end else begin
        m_x++;
      end
    end
    @(posedge iCLK);
    #1;
  endtask

  // One 8x8 frame: columns < split get lo, the rest hi; optional kernel
  // rewrite before row wr_row and an optional write on the SOF cycle.
  task automatic frame(input int lo, input int hi, input int split, input int wr_row,
                       input bit sof_we, input int sof_addr, input int sof_data,
                       output int base);
    base = out_pix.size();
    for (int y = 0; y < IMG_W; y++) begin
      if (y == wr_row) begin
        for (int k = 0; k < 9; k++) step(0, 1'b0, 1'b0, 1'b1, k, (k == 4) ? 1 : 0);
        step(0, 1'b0, 1'b0, 1'b1, 12, 5);
      end
      for (int x = 0; x < IMG_W; x++) begin
        if (x == 0 && y == 0) step((x < split) ? lo : hi, 1'b1, 1'b1, sof_we, sof_addr, sof_data);
        else step((x < split) ? lo : hi, 1'b1, 1'b0);
      end
    end
    repeat (5) step(0, 1'b0, 1'b0);
  endtask

  // Compare process: oDVAL every cycle, data/edge whenever an output is due.
  initial begin
    exp_t e;
    bit   exp_dv;
    forever begin
      @(negedge iCLK);
      if (iRST) begin
        dv_sh = 3'b000;
      end else begin
        exp_dv = dv_sh[2];
        check("odval", int'(oDVAL), int'(exp_dv));
        if (exp_dv) begin
          out_pix.push_back(int'(oPIX));
          out_edg.push_back(oEDGE);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL model_queue: got output %0d expected none", oPIX);
          end else begin
            e = exp_q.pop_front();
            if (e.chk) check("opix", int'(oPIX), e.pix);
            check("oedge", int'(oEDGE), int'(e.edg));
          end
        end
        dv_sh = {dv_sh[1:0], iDVAL};
      end
    end
  end

  initial begin
    int b;
    logic [3:0] lat;
    model_reset();
    #2 iRST = 1'b1;
    #2;
    check("rst_opix", int'(oPIX), 0);
    check("rst_odval", int'(oDVAL), 0);
    check("rst_oedge", int'(oEDGE), 0);
    @(posedge iCLK); @(posedge iCLK); #1;
    iRST = 1'b0;

    // single-pulse latency
    step(5, 1'b1, 1'b1);
    lat[0] = oDVAL;
    for (int i = 1; i < 4; i++) begin step(0, 1'b0, 1'b0); lat[i] = oDVAL; end
    check("lat_single", int'(lat), 4'b0100);
    // gapped 1-0-1
    step(1, 1'b1, 1'b0); step(0, 1'b0, 1'b0); step(2, 1'b1, 1'b0);
    lat[0] = oDVAL;
    for (int i = 1; i < 3; i++) begin step(0, 1'b0, 1'b0); lat[i] = oDVAL; end
    lat[3] = 1'b0;
    check("lat_gapped", int'(lat), 4'b0101);
    repeat (3) step(0, 1'b0, 1'b0);

    // vertical edge, Sobel-X magnitude
    frame(0, 1000, 4, -1, 1'b0, 0, 0, b);
    lit("edge_c3", b + 28, 4000, 0);
    lit("edge_c4", b + 29, 4000, 0);
    lit("flat_c5", b + 30, 0, 0);

    // clamp high, then inverted step with offset and shift
    frame(0, PMAX, 4, -1, 1'b0, 0, 0, b);
    lit("clamp_hi", b + 28, PMAX, 0);
    iABS = 1'b0; iSHIFT = 4'd2;
    frame(PMAX, 0, 4, -1, 1'b0, 0, 0, b);
    lit("clamp_lo", b + 28, 0, 0);
    lit("offset_mid", b + 30, PMID, 0);
    iABS = 1'b1; iSHIFT = 4'd0;

    // border handling
    iBORDER_ZERO = 1'b1;
    frame(0, 1000, 4, -1, 1'b0, 0, 0, b);
    lit("bz_origin", b + 0, 0, 1);
    lit("bz_x1", b + 9, 0, 1);
    lit("bz_row1", b + 12, 0, 1);
    lit("bz_interior", b + 28, 4000, 0);
    iBORDER_ZERO = 1'b0;
    frame(0, 1000, 4, -1, 1'b0, 0, 0, b);
    lit("nobz_row1", b + 12, 4000, 1);
    lit("nobz_interior", b + 29, 4000, 0);

    // shadow kernel: mid-frame rewrite to identity, ignored address 12
    frame(0, 1000, 4, 4, 1'b0, 0, 0, b);
    lit("shadow_hold", b + 52, 4000, 0);
    frame(0, 1000, 4, -1, 1'b1, 12, 7, b);
    lit("identity_c3", b + 28, 0, 0);
    lit("identity_c4", b + 29, 1000, 0);
    frame(0, 1000, 4, -1, 1'b1, 4, 2, b);
    lit("commit_same_cycle", b + 29, 2000, 0);

    // reset while streaming, then kernel readback on a flat frame
    iCONV_EN = 1'b0;
    for (int i = 0; i < 12; i++) step(50, 1'b1, i == 0);
    iRST = 1'b1;
    #1;
    check("midrst_opix", int'(oPIX), 0);
    check("midrst_odval", int'(oDVAL), 0);
    check("midrst_oedge", int'(oEDGE), 0);
    iDVAL = 1'b0; iSOF = 1'b0;
    model_reset();
    @(posedge iCLK); @(posedge iCLK); #1;
    iRST = 1'b0;
    iCONV_EN = 1'b1;
    step(0, 1'b0, 1'b0);
    frame(100, 100, 4, -1, 1'b0, 0, 0, b);
    lit("readback_a", b + 28, 0, 0);
    lit("readback_b", b + 45, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
